// File: rtl/tbench_pkg.sv
// Shared types and helpers for the APB3 register-file slave.
// Optional error response: TBENCH_APB3_SLAVE_PSLVERR_EN.
package tbench_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_t;

  function automatic int IDX_W(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tbench_regfile.sv
// DEPTH x 32 register storage, one write port, one registered read port.
// Read data is forced to zero when no read is requested.
module tbench_regfile
  import tbench_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                IW        = IDX_W(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IW-1:0]     i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IW-1:0]     i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_VAL;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_widx] <= i_wdata;
      end
      r_rdata <= i_re ? r_mem[i_ridx] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tbench_apb3_slave.sv
// APB3 register-file slave: FSM, wait-state counter and error decode.
// Optional error response on out-of-range addresses: TBENCH_APB3_SLAVE_PSLVERR_EN.
module tbench_apb3_slave
  import tbench_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IW = IDX_W(DEPTH);

  apb_state_t    r_state;
  apb_state_t    w_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_pready;
  logic          w_go;
  logic          w_oor;
  logic          w_err;
  logic          w_we;
  logic          w_re;
  logic [IW-1:0] w_idx;
  logic          w_unused;

  assign w_idx    = paddr[2 +: IW];
  assign w_oor    = |paddr[ADDR_W-1:IW+2];
  assign w_unused = ^{paddr[1:0], w_oor};

`ifdef TBENCH_APB3_SLAVE_PSLVERR_EN
  logic r_pslverr;

  assign w_err = w_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pslverr <= 1'b0;
    end else begin
      r_pslverr <= w_go & w_err;
    end
  end

  assign pslverr = r_pslverr;
`else
  assign w_err   = 1'b0;
  assign pslverr = 1'b0;
`endif

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_go      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_nxt     = WAIT;
          w_cnt_nxt = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (!psel) begin
          w_nxt = IDLE;
        end else if (penable && r_cnt == 4'd0) begin
          w_go  = 1'b1;
          w_nxt = DONE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        w_nxt = IDLE;
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_pready <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pready <= w_go;
    end
  end

  // Address and data are held by the master through the ready cycle.
  assign w_we = r_pready & psel & penable & pwrite & ~w_err;
  assign w_re = w_go & ~pwrite & ~w_err;

  tbench_regfile #(
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL),
    .IW        (IW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_widx  (w_idx),
    .i_wdata (pwdata),
    .i_re    (w_re),
    .i_ridx  (w_idx),
    .o_rdata (prdata)
  );

  assign pready = r_pready;

endmodule

// File: tb/tb_tbench_apb3_slave.sv
// Bench for tbench_apb3_slave: one zero-wait and one 3-wait instance.
// Expected responses are queued at setup and checked at pready.
module tb_tbench_apb3_slave;

`ifdef TBENCH_APB3_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic        e;
    bit          rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n0;
  logic        rst_n1;
  logic        psel0;
  logic        psel1;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata0;
  logic [31:0] prdata1;
  logic        pready0;
  logic        pready1;
  logic        pslverr0;
  logic        pslverr1;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  tbench_apb3_slave #(
    .WAIT_STATES (0)
  ) dut0 (
    .clk     (clk),
    .rst_n   (rst_n0),
    .psel    (psel0),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata0),
    .pready  (pready0),
    .pslverr (pslverr0)
  );

  tbench_apb3_slave #(
    .WAIT_STATES (3)
  ) dut1 (
    .clk     (clk),
    .rst_n   (rst_n1),
    .psel    (psel1),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata1),
    .pready  (pready1),
    .pslverr (pslverr1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int s, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_d,
                      input logic exp_e);
    exp_t e;
    int   cyc;
    int   ws;
    logic rdy;
    ws = (s == 0) ? 0 : 3;
    @(negedge clk);
    if (s == 0) psel0 = 1'b1;
    else psel1 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    e.d  = exp_d;
    e.e  = exp_e;
    e.rd = !wr;
    sb.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      rdy = (s == 0) ? pready0 : pready1;
    end
    e = sb.pop_front();
    if (!rdy) begin
      chk("timeout", 32'(rdy), 32'd1);
    end else begin
      chk("latency", 32'(cyc), 32'(ws + 1));
      if (e.rd) chk("rdata", (s == 0) ? prdata0 : prdata1, e.d);
      chk("pslverr", 32'((s == 0) ? pslverr0 : pslverr1), 32'(e.e));
    end
    @(posedge clk);
    #1;
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    chk("ready_one_cycle", 32'((s == 0) ? pready0 : pready1), 32'd0);
    chk("rdata_idle", (s == 0) ? prdata0 : prdata1, 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n0  = 1'b0;
    rst_n1  = 1'b0;
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_pready", 32'(pready0), 32'd0);
    chk("rst_prdata", prdata0, 32'd0);
    chk("rst_pslverr", 32'(pslverr0), 32'd0);
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;

    xfer(0, 1'b0, 32'h0, '0, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h0, 32'h0000AAAA, '0, 1'b0);
    xfer(0, 1'b0, 32'h0, '0, 32'h0000AAAA, 1'b0);
    xfer(0, 1'b1, 32'h4, 32'h11111111, '0, 1'b0);
    xfer(0, 1'b1, 32'h3C, 32'h22222222, '0, 1'b0);
    xfer(0, 1'b0, 32'h4, '0, 32'h11111111, 1'b0);
    xfer(0, 1'b0, 32'h3C, '0, 32'h22222222, 1'b0);
    xfer(0, 1'b0, 32'h3, '0, 32'h0000AAAA, 1'b0);

    xfer(0, 1'b1, 32'h40, 32'hDEADBEEF, '0, ERR_EN);
    xfer(0, 1'b0, 32'h0, '0, ERR_EN ? 32'h0000AAAA : 32'hDEADBEEF, 1'b0);
    xfer(0, 1'b0, 32'h44, '0, ERR_EN ? 32'h0 : 32'h11111111, ERR_EN);

    xfer(1, 1'b1, 32'h10, 32'hCAFEF00D, '0, 1'b0);
    xfer(1, 1'b0, 32'h10, '0, 32'hCAFEF00D, 1'b0);

    // Abort in the wait phase: no ready, no write.
    @(negedge clk);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'hC; pwdata = 32'h55;
    @(negedge clk);
    penable = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= pready1;
    end
    psel1 = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= pready1;
    end
    chk("abort_ready", 32'(seen), 32'd0);
    xfer(1, 1'b0, 32'hC, '0, 32'h0, 1'b0);

    // Reset in the wait phase of a write.
    @(negedge clk);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h8; pwdata = 32'h12345678;
    @(negedge clk);
    penable = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= pready1;
    end
    rst_n1 = 1'b0;
    #1;
    chk("midrst_pready", 32'(pready1), 32'd0);
    chk("midrst_prdata", prdata1, 32'd0);
    repeat (3) begin
      @(negedge clk);
      seen |= pready1;
    end
    psel1 = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n1 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen |= pready1;
    end
    chk("midrst_no_ready", 32'(seen), 32'd0);
    xfer(1, 1'b0, 32'h8, '0, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h4, '0, 32'h11111111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
